// File: rtl/eggtimer_pkg.sv
// Shared types, field widths and the binary-to-BCD helper for the egg-timer
// timekeeping datapath.
package eggtimer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam int SEC_MAX = 59;
  localparam int SEC_W   = 6;
  localparam int MIN_W   = 7;
  localparam int BCD_W   = 4;

  // Split a binary value in 0..99 into {tens, ones} BCD digits.
  function automatic logic [2*BCD_W-1:0] to_bcd(input logic [MIN_W-1:0] v);
    return {BCD_W'(v / MIN_W'(10)), BCD_W'(v % MIN_W'(10))};
  endfunction

endpackage

// File: rtl/eggtimer_tick_gen.sv
// One-second prescaler: counts clk cycles while enabled and emits a
// single-cycle tick on the last count of each second.
module eggtimer_tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Clear wins over counting; a disabled prescaler holds its sub-second phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + CW'(1);
    end
  end

  // A clear in the same cycle suppresses the tick so load/start beat a due decrement.
  assign tick = en & ~clr & (count == LAST);

endmodule

// File: rtl/eggtimer_counter.sv
// mm:ss countdown register with its run/pause/expire state machine, status
// flags back to the controller and BCD digits for the display.
module eggtimer_counter
  import eggtimer_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int MAX_MIN  = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       start,
  input  logic       countdown,
  input  logic [6:0] min_in,
  input  logic [5:0] sec_in,
  output logic       zero,
  output logic       endd,
  output logic       done,
  output logic       expired,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam logic [MIN_W-1:0] MAX_MIN_L = MIN_W'(MAX_MIN);
  localparam logic [SEC_W-1:0] SEC_MAX_L = SEC_W'(SEC_MAX);

  state_t           state;
  logic [MIN_W-1:0] min_q;
  logic [SEC_W-1:0] sec_q;
  logic [MIN_W-1:0] min_load;
  logic [SEC_W-1:0] sec_load;
  logic             tick;
  logic             pre_en;
  logic             pre_clr;
  logic             last_tick;
  logic [7:0]       min_bcd;
  logic [7:0]       sec_bcd;

  assign pre_en  = countdown & (state == RUNNING);
  assign pre_clr = load | start;

  eggtimer_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  assign min_load  = (min_in > MAX_MIN_L) ? MAX_MIN_L : min_in;
  assign sec_load  = (sec_in > SEC_MAX_L) ? SEC_MAX_L : sec_in;

  assign zero      = (sec_q == '0);
  assign endd      = (min_q == '0);
  assign last_tick = tick & endd & (sec_q == SEC_W'(1));

  // Time register: preset on load, otherwise step down one second per tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      sec_q <= '0;
    end else if (load) begin
      min_q <= min_load;
      sec_q <= sec_load;
    end else if (tick) begin
      if (sec_q != '0) begin
        sec_q <= sec_q - SEC_W'(1);
      end else if (min_q != '0) begin
        min_q <= min_q - MIN_W'(1);
        sec_q <= SEC_MAX_L;
      end
    end
  end

  // Run/pause/expire control with registered done pulse and expired level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state   <= IDLE;
        expired <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (countdown && !(zero && endd)) state <= RUNNING;
          end
          RUNNING: begin
            if (last_tick) begin
              state   <= EXPIRED;
              done    <= 1'b1;
              expired <= 1'b1;
            end else if (!countdown) begin
              state <= IDLE;
            end
          end
          EXPIRED: begin
            state <= EXPIRED;
          end
          default: begin
            state   <= IDLE;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

  assign min_bcd  = to_bcd(min_q);
  assign sec_bcd  = to_bcd({1'b0, sec_q});
  assign min_tens = min_bcd[7:4];
  assign min_ones = min_bcd[3:0];
  assign sec_tens = sec_bcd[7:4];
  assign sec_ones = sec_bcd[3:0];

endmodule

// File: tb/tb_eggtimer_counter.sv
// Scoreboard bench for eggtimer_counter: a seconds-based reference model
// predicts each cycle's outputs, a monitor compares them after every edge.
module tb_eggtimer_counter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       start;
  logic       countdown;
  logic [6:0] min_in;
  logic [5:0] sec_in;
  logic       zero;
  logic       endd;
  logic       done;
  logic       expired;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;

  always #5 clk = ~clk;

  eggtimer_counter #(
    .TICK_DIV (TD),
    .MAX_MIN  (99)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .start     (start),
    .countdown (countdown),
    .min_in    (min_in),
    .sec_in    (sec_in),
    .zero      (zero),
    .endd      (endd),
    .done      (done),
    .expired   (expired),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones)
  );

  typedef struct {
    int mn;
    int sc;
    bit zero;
    bit endd;
    bit done;
    bit expired;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   done_seen = 0;

  // Reference model: remaining time held as total seconds.
  int m_total;
  int m_phase;
  bit m_run;
  bit m_exp;
  bit m_done;

  function automatic void model_reset();
    m_total = 0;
    m_phase = 0;
    m_run   = 0;
    m_exp   = 0;
    m_done  = 0;
  endfunction

  function automatic void model_step();
    int mi;
    int si;
    bit tk;
    if (rst) begin
      model_reset();
    end else if (load) begin
      mi      = (int'(min_in) > 99) ? 99 : int'(min_in);
      si      = (int'(sec_in) > 59) ? 59 : int'(sec_in);
      m_total = mi * 60 + si;
      m_phase = 0;
      m_run   = 0;
      m_exp   = 0;
      m_done  = 0;
    end else begin
      tk     = m_run && countdown && !start && (m_phase == TD - 1);
      m_done = tk && (m_total == 1);
      if (start) m_phase = 0;
      else if (m_run && countdown) m_phase = (m_phase + 1) % TD;
      if (tk && m_total > 0) m_total = m_total - 1;
      if (m_exp) begin
        m_exp = 1;
      end else if (m_run) begin
        if (m_done) begin
          m_run = 0;
          m_exp = 1;
        end else if (!countdown) begin
          m_run = 0;
        end
      end else if (countdown && m_total != 0) begin
        m_run = 1;
      end
    end
  endfunction

  function automatic exp_t expected();
    exp_t e;
    e.mn      = m_total / 60;
    e.sc      = m_total % 60;
    e.zero    = (e.sc == 0);
    e.endd    = (e.mn == 0);
    e.done    = m_done;
    e.expired = m_exp;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int cur_min();
    return int'(min_tens) * 10 + int'(min_ones);
  endfunction

  function automatic int cur_sec();
    return int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  // Drive one cycle of inputs at negedge, predict the post-edge state, return after the edge.
  task automatic step(input bit l, input bit s, input bit c, input int mi, input int si);
    @(negedge clk);
    load      = l;
    start     = s;
    countdown = c;
    min_in    = 7'(mi);
    sec_in    = 6'(si);
    model_step();
    q.push_back(expected());
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge with a pending prediction is compared field by field.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("min_tens", int'(min_tens), e.mn / 10);
        chk("min_ones", int'(min_ones), e.mn % 10);
        chk("sec_tens", int'(sec_tens), e.sc / 10);
        chk("sec_ones", int'(sec_ones), e.sc % 10);
        chk("zero",     int'(zero),     int'(e.zero));
        chk("endd",     int'(endd),     int'(e.endd));
        chk("done",     int'(done),     int'(e.done));
        chk("expired",  int'(expired),  int'(e.expired));
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; load = 1'b0; start = 1'b0; countdown = 1'b0;
    min_in = '0; sec_in = '0;
    model_reset();
    #1;
    chk("rst_zero",    int'(zero),    1);
    chk("rst_endd",    int'(endd),    1);
    chk("rst_min",     cur_min(),     0);
    chk("rst_sec",     cur_sec(),     0);
    chk("rst_expired", int'(expired), 0);
    chk("rst_done",    int'(done),    0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // countdown at 00:00 must not start a run
    done_seen = 0;
    repeat (10) step(0, 0, 1, 0, 0);
    chk("idle_zero_done_count", done_seen, 0);
    chk("idle_zero_expired", int'(expired), 0);

    // load 1:02 and run through the minute wrap
    step(1, 0, 0, 1, 2);
    repeat (5) step(0, 0, 1, 0, 0);
    chk("run_1_01_min", cur_min(), 1);
    chk("run_1_01_sec", cur_sec(), 1);
    repeat (4) step(0, 0, 1, 0, 0);
    chk("run_1_00_sec", cur_sec(), 0);
    chk("run_1_00_zero", int'(zero), 1);
    repeat (4) step(0, 0, 1, 0, 0);
    chk("run_0_59_min", cur_min(), 0);
    chk("run_0_59_sec", cur_sec(), 59);
    chk("run_0_59_endd", int'(endd), 1);
    chk("run_0_59_zero", int'(zero), 0);
    step(0, 0, 0, 0, 0);

    // expiry from 0:02
    step(1, 0, 0, 0, 2);
    done_seen = 0;
    repeat (9) step(0, 0, 1, 0, 0);
    chk("expire_done_pulse", int'(done), 1);
    repeat (6) step(0, 0, 1, 0, 0);
    chk("expire_done_count", done_seen, 1);
    chk("expire_level", int'(expired), 1);
    chk("expire_sec", cur_sec(), 0);
    step(1, 0, 0, 0, 5);
    chk("reload_expired", int'(expired), 0);
    chk("reload_sec", cur_sec(), 5);

    // pause keeps sub-second phase
    step(1, 0, 0, 0, 10);
    repeat (7) step(0, 0, 1, 0, 0);
    chk("pause_pre_sec", cur_sec(), 9);
    repeat (20) step(0, 0, 0, 0, 0);
    chk("pause_hold_sec", cur_sec(), 9);
    repeat (2) step(0, 0, 1, 0, 0);
    chk("resume_not_yet", cur_sec(), 9);
    step(0, 0, 1, 0, 0);
    chk("resume_decrement", cur_sec(), 8);

    // clamp and start-beats-tick
    step(1, 0, 0, 120, 63);
    chk("clamp_min", cur_min(), 99);
    chk("clamp_sec", cur_sec(), 59);
    guard = 0;
    while (!(m_run && m_phase == TD - 1) && guard < 20) begin
      step(0, 0, 1, 0, 0);
      guard++;
    end
    chk("clamp_reach_tick_bound", int'(guard < 20), 1);
    step(0, 1, 1, 0, 0);
    chk("start_blocks_tick", cur_sec(), 59);
    repeat (3) step(0, 0, 1, 0, 0);
    chk("start_realign_wait", cur_sec(), 59);
    step(0, 0, 1, 0, 0);
    chk("start_realign_tick", cur_sec(), 58);

    // asynchronous reset mid-run
    step(1, 0, 0, 0, 10);
    guard = 0;
    while (m_total != 7 && guard < 100) begin
      step(0, 0, 1, 0, 0);
      guard++;
    end
    chk("arst_pre_sec", cur_sec(), 7);
    #1 rst = 1'b1;
    #1;
    chk("arst_sec",     cur_sec(),     0);
    chk("arst_zero",    int'(zero),    1);
    chk("arst_endd",    int'(endd),    1);
    chk("arst_expired", int'(expired), 0);
    model_reset();
    step(0, 0, 1, 0, 0);
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit l, s, c;
      int mi, si;
      l  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 9) == 0);
      c  = ($urandom_range(0, 9) != 0);
      mi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 1));
      si = int'($urandom_range(0, 63));
      step(l, s, c, mi, si);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/eggtimer_counter.md
Name: eggtimer_counter

Overview:
- Timekeeping datapath directly downstream of the egg-timer controller.
- Consumes the controller's `load`, `start` and `countdown` outputs and holds the mm:ss remaining time.
- Decrements the time once per second while enabled.
- Returns `zero` (seconds field is 0) and `endd` (minutes field is 0) to the controller, and drives BCD digits to the display stage.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second tick (benches override to a small value).
- MAX_MIN, 99, largest loadable minutes value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- load  in  1  level; load the preset time from sec_in/min_in
- start  in  1  level; while high, prescaler held cleared (aligns first tick to a full second after release)
- countdown  in  1  level; enables prescaler and decrement
- min_in  in  7  preset minutes, binary
- sec_in  in  6  preset seconds, binary
- zero  out  1  seconds register == 0
- endd  out  1  minutes register == 0
- done  out  1  one-cycle pulse on the tick that reaches 00:00
- expired  out  1  level; FSM in EXPIRED
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD of current time

Behaviour:
- Reset (async, rst=1): min=0, sec=0, prescaler=0, FSM=IDLE, done=0, expired=0. Consequently zero=1, endd=1 and all BCD digits read 0.
- zero and endd are combinational from the registers (no added latency).
- BCD outputs are combinational from the registers.
- Prescaler:
  - Counts 0..TICK_DIV-1 while countdown=1 and FSM=RUNNING.
  - tick asserts for the one cycle in which the count equals TICK_DIV-1; the count then wraps to 0.
  - Holds its value when countdown=0 (pause preserves the sub-second phase).
  - Cleared when load=1 or start=1.
- Load, registered next edge:
  - min <= min(min_in, MAX_MIN).
  - sec <= min(sec_in, 59); i.e. out-of-range values clamp, sec_in=63 gives 59.
  - FSM -> IDLE; expired clears.
- Priority, highest first: rst > load > start > tick. start and tick in the same cycle: start wins; no decrement, prescaler cleared.
- Decrement on tick:
  - sec>0: sec-1.
  - sec==0 and min>0: min-1, sec<=59 (wrap).
  - sec==0 and min==0: no change (cannot occur in RUNNING; guard only).
- FSM states IDLE, RUNNING, EXPIRED:
  - IDLE -> RUNNING: countdown=1 and not (zero & endd).
  - IDLE stays IDLE if countdown=1 at 00:00: no run, no done.
  - RUNNING -> IDLE: countdown=0. This is a pause; time and prescaler are held, and re-asserting countdown resumes.
  - RUNNING -> EXPIRED: the tick that makes the time 00:00. done=1 for exactly that cycle.
  - EXPIRED: holds 00:00, expired=1; countdown is ignored. Only load (or rst) leaves, to IDLE.
- done is registered: high in the cycle after the final tick edge, same cycle the registers first show 00:00.
- Load during RUNNING: new value takes effect next edge, FSM -> IDLE; the controller's countdown re-enters RUNNING on the following cycle if still high.
- rst mid-run: immediate clear regardless of clk.

Decomposition:
- Package eggtimer_pkg holds:
  - typedef state_t {IDLE, RUNNING, EXPIRED}
  - constants SEC_MAX=59, SEC_W=6, MIN_W=7, BCD_W=4
- Sub-module eggtimer_tick_gen: parameter TICK_DIV; inputs clk, rst, clr, en; output tick. It contains the prescaler.
- Binary-to-BCD split (divide/modulo by 10, 0..99) is a function in the package, not a module.

Test Plan (TICK_DIV=4):
- Reset, then idle: rst pulse -> zero=1, endd=1, all BCD=0, expired=0; countdown=1 at 00:00 -> FSM stays IDLE, done never asserts.
- Load 1:02, then run:
  - load=1 one cycle with min_in=1, sec_in=2; then countdown=1.
  - Time reads 1:01 after 4 cycles, 1:00 after 8, 0:59 after 12 (min/sec wrap).
  - zero=1 only while sec=0; endd=1 from 0:59 on.
- Expiry: load 0:02, countdown=1 -> done pulses exactly once, 8 cycles after run start; expired=1; further countdown cycles leave 00:00; load 0:05 -> expired=0, IDLE.
- Pause/resume phase: load 0:10, run 6 cycles (one tick, prescaler at 2), countdown=0 for 20 cycles -> time stays 0:09; resume -> next decrement after 2 cycles.
- Clamp and priority: load min_in=120, sec_in=63 -> 99:59. Assert start on the cycle a tick is due -> no decrement; next tick 4 cycles after start drops.
- Async reset mid-run: assert rst between clk edges at 0:07 -> outputs clear immediately, before the next edge.
